// File: rtl/ram_arbiter_if.sv
// Bus bundle for ram_arbiter: two requester command ports (A and B), the
// single-port RAM control/data bus and the busy flag.
//   slave  : arbiter side (takes requests and ram_dout, drives gnt/done/rdata/RAM bus/busy)
//   master : environment side (requesters plus RAM model)
interface ram_arbiter_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 4
) ();
  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_done;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_done;
  logic [DATA_W-1:0] b_rdata;

  logic              ram_rd_n;
  logic              ram_wr_n;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  logic              busy;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  ram_dout,
    output a_gnt, a_done, a_rdata,
    output b_gnt, b_done, b_rdata,
    output ram_rd_n, ram_wr_n, ram_addr, ram_din,
    output busy
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output ram_dout,
    input  a_gnt, a_done, a_rdata,
    input  b_gnt, b_done, b_rdata,
    input  ram_rd_n, ram_wr_n, ram_addr, ram_din,
    input  busy
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin arbiter giving two requesters (A, B) access to one single-port
// RAM with registered read data.
// Ports:
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ram_arbiter_if.slave (requester ports, RAM bus, busy)
// Flow: IDLE grant edge latches the winning command -> ACCESS (one enable
// low for one cycle) -> write: IDLE with done; read: CAPTURE -> IDLE with
// rdata/done. All outputs are registered.
module ram_arbiter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 4
) (
  input logic           clk,
  input logic           rst_n,
  ram_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StCapture} state_e;

  state_e            state_q;
  logic              last_b_q;   // 1: B was granted last, so A wins a tie
  logic              owner_b_q;  // requester owning the command in flight
  logic              we_q;
  logic              rd_n_q;
  logic              wr_n_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;
  logic              a_gnt_q;
  logic              b_gnt_q;
  logic              a_done_q;
  logic              b_done_q;

  logic              any_req;
  logic              pick_b;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // B wins when it is the only requester, or on a tie when A went last.
  assign any_req   = bus.a_req | bus.b_req;
  assign pick_b    = bus.b_req & (~bus.a_req | ~last_b_q);
  assign win_we    = pick_b ? bus.b_we    : bus.a_we;
  assign win_addr  = pick_b ? bus.b_addr  : bus.a_addr;
  assign win_wdata = pick_b ? bus.b_wdata : bus.a_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      last_b_q  <= 1'b1;
      owner_b_q <= 1'b0;
      we_q      <= 1'b0;
      rd_n_q    <= 1'b1;
      wr_n_q    <= 1'b1;
      addr_q    <= '0;
      din_q     <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      a_gnt_q   <= 1'b0;
      b_gnt_q   <= 1'b0;
      a_done_q  <= 1'b0;
      b_done_q  <= 1'b0;
    end else begin
      // Pulses and enables default inactive; each is raised for one cycle only.
      a_gnt_q  <= 1'b0;
      b_gnt_q  <= 1'b0;
      a_done_q <= 1'b0;
      b_done_q <= 1'b0;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            owner_b_q <= pick_b;
            last_b_q  <= pick_b;
            we_q      <= win_we;
            addr_q    <= win_addr;
            din_q     <= win_wdata;
            a_gnt_q   <= ~pick_b;
            b_gnt_q   <= pick_b;
            // Enables go low together with entering ACCESS, and only one of them.
            wr_n_q    <= ~win_we;
            rd_n_q    <= win_we;
            state_q   <= StAccess;
          end
        end
        StAccess: begin
          if (we_q) begin
            a_done_q <= ~owner_b_q;
            b_done_q <= owner_b_q;
            state_q  <= StIdle;
          end else begin
            state_q  <= StCapture;
          end
        end
        StCapture: begin
          if (owner_b_q) begin
            b_rdata_q <= bus.ram_dout;
          end else begin
            a_rdata_q <= bus.ram_dout;
          end
          a_done_q <= ~owner_b_q;
          b_done_q <= owner_b_q;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.a_gnt    = a_gnt_q;
  assign bus.b_gnt    = b_gnt_q;
  assign bus.a_done   = a_done_q;
  assign bus.b_done   = b_done_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rdata  = b_rdata_q;
  assign bus.ram_rd_n = rd_n_q;
  assign bus.ram_wr_n = wr_n_q;
  assign bus.ram_addr = addr_q;
  assign bus.ram_din  = din_q;
  assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed commands with hand-computed results queued
// as expectations, a monitor that pops/compares on gnt and done, per-cycle
// bus invariants, a reset-abort case and a random phase.
module tb_ram_arbiter;
  localparam int unsigned AW = 4;
  localparam int unsigned DW = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  bit   rnd   = 1'b0;

  ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: registered read, both enables low clears the output.
  logic [DW-1:0] mem [16] = '{default: '0};
  logic [DW-1:0] ram_dout_q = '0;
  assign bus.ram_dout = ram_dout_q;
  always @(posedge clk) begin
    if (!bus.ram_rd_n && !bus.ram_wr_n) ram_dout_q <= '0;
    else if (!bus.ram_wr_n) mem[bus.ram_addr] <= bus.ram_din;
    else if (!bus.ram_rd_n) ram_dout_q <= mem[bus.ram_addr];
  end

  typedef struct {bit who; logic we; logic [AW-1:0] addr; logic [DW-1:0] wdata;} gexp_t;
  typedef struct {logic we; logic [DW-1:0] rdata; int dcyc;} dexp_t;
  gexp_t gq[$];
  dexp_t qa[$];
  dexp_t qb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_done(input string who, input dexp_t d, input logic [DW-1:0] rdata);
    if (d.dcyc >= 0) check({who, "_done_cycle"}, 32'(cyc), 32'(d.dcyc));
    if (!d.we) check({who, "_rdata"}, 32'(rdata), 32'(d.rdata));
  endtask

  // Monitor: invariants every cycle, scoreboard pops on gnt/done.
  initial begin : mon
    bit    cap_pending;
    logic  exp_busy;
    logic  cur_we;
    gexp_t g;
    dexp_t d;
    cap_pending = 1'b0;
    forever begin
      @(negedge clk);
      exp_busy = rst_n && (bus.a_gnt || bus.b_gnt || cap_pending);
      check("busy", 32'(bus.busy), 32'(exp_busy));
      check("both_en_low", 32'(!bus.ram_rd_n && !bus.ram_wr_n), 32'd0);
      check("both_gnt", 32'(bus.a_gnt && bus.b_gnt), 32'd0);
      check("both_done", 32'(bus.a_done && bus.b_done), 32'd0);
      if (!bus.a_gnt && !bus.b_gnt)
        check("en_outside_access", 32'({bus.ram_rd_n, bus.ram_wr_n}), 32'd3);
      cur_we = 1'b1;
      if (bus.a_gnt || bus.b_gnt) begin
        if (rnd) begin
          cur_we = bus.a_gnt ? bus.a_we : bus.b_we;
        end else if (gq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL gnt_unexpected: got a=%0b b=%0b want none", bus.a_gnt, bus.b_gnt);
        end else begin
          g = gq.pop_front();
          check("gnt_who", 32'(bus.b_gnt), 32'(g.who));
          cur_we = g.we;
          check("ram_addr", 32'(bus.ram_addr), 32'(g.addr));
          if (g.we) begin
            check("wr_n", 32'(bus.ram_wr_n), 32'd0);
            check("ram_din", 32'(bus.ram_din), 32'(g.wdata));
          end else begin
            check("rd_n", 32'(bus.ram_rd_n), 32'd0);
          end
        end
      end
      cap_pending = rst_n && (bus.a_gnt || bus.b_gnt) && !cur_we;
      if (!rnd && bus.a_done) begin
        if (qa.size() == 0) begin
          total++;
          bad++;
          $display("FAIL a_done_unexpected: got 1 want 0");
        end else begin
          d = qa.pop_front();
          chk_done("a", d, bus.a_rdata);
        end
      end
      if (!rnd && bus.b_done) begin
        if (qb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL b_done_unexpected: got 1 want 0");
        end else begin
          d = qb.pop_front();
          chk_done("b", d, bus.b_rdata);
        end
      end
    end
  end

  task automatic drive(input bit who, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata);
    if (who) begin
      bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata;
    end else begin
      bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wdata;
    end
  endtask

  task automatic expect_cmd(input bit who, input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input logic [DW-1:0] rdata,
                            input int dcyc);
    gexp_t g;
    dexp_t d;
    g.who = who; g.we = we; g.addr = addr; g.wdata = wdata;
    d.we = we; d.rdata = rdata; d.dcyc = dcyc;
    gq.push_back(g);
    if (who) qb.push_back(d);
    else qa.push_back(d);
  endtask

  // Drops each request on its grant and scrambles the inputs, then waits until all done.
  task automatic run_until_quiet(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      #1;
      if (bus.a_gnt) begin
        bus.a_req = 1'b0; bus.a_we = 1'($urandom);
        bus.a_addr = AW'($urandom); bus.a_wdata = DW'($urandom);
      end
      if (bus.b_gnt) begin
        bus.b_req = 1'b0; bus.b_we = 1'($urandom);
        bus.b_addr = AW'($urandom); bus.b_wdata = DW'($urandom);
      end
      if (!bus.a_req && !bus.b_req && gq.size() == 0 && qa.size() == 0 &&
          qb.size() == 0 && !bus.busy) return;
    end
    total++;
    bad++;
    $display("FAIL %s_timeout: got pending gq=%0d qa=%0d qb=%0d want 0", name,
             gq.size(), qa.size(), qb.size());
    gq.delete(); qa.delete(); qb.delete();
    bus.a_req = 1'b0; bus.b_req = 1'b0;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    int gcnt;
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = '0; bus.a_wdata = '0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = '0; bus.b_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_rd_n", 32'(bus.ram_rd_n), 32'd1);
    check("rst_wr_n", 32'(bus.ram_wr_n), 32'd1);
    check("rst_addr", 32'(bus.ram_addr), 32'd0);
    check("rst_din", 32'(bus.ram_din), 32'd0);
    check("rst_rdata", 32'({bus.a_rdata, bus.b_rdata}), 32'd0);
    check("rst_pulses", 32'({bus.a_gnt, bus.b_gnt, bus.a_done, bus.b_done}), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;

    // Both held from reset: grants alternate A,B,A,B.
    drive(0, 1, 4'd1, 4'h1);
    drive(1, 1, 4'd2, 4'h2);
    expect_cmd(0, 1, 4'd1, 4'h1, 4'h0, -1);
    expect_cmd(1, 1, 4'd2, 4'h2, 4'h0, -1);
    expect_cmd(0, 1, 4'd1, 4'h1, 4'h0, -1);
    expect_cmd(1, 1, 4'd2, 4'h2, 4'h0, -1);
    gcnt = 0;
    for (int i = 0; i < 100 && gcnt < 4; i++) begin
      @(negedge clk);
      #1;
      if (bus.a_gnt || bus.b_gnt) gcnt++;
      if (gcnt == 4) begin
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
      end
    end
    check("alternate_grant_count", 32'(gcnt), 32'd4);
    run_until_quiet("alternate");

    // A write 3 <- A then A read 3 (latencies 2 and 3).
    n = cyc; drive(0, 1, 4'd3, 4'hA); expect_cmd(0, 1, 4'd3, 4'hA, 4'h0, n + 2);
    run_until_quiet("a_write");
    n = cyc; drive(0, 0, 4'd3, 4'h0); expect_cmd(0, 0, 4'd3, 4'h0, 4'hA, n + 3);
    run_until_quiet("a_read");

    // B read 2 (written by B above); leaves B as last granted.
    n = cyc; drive(1, 0, 4'd2, 4'h0); expect_cmd(1, 0, 4'd2, 4'h0, 4'h2, n + 3);
    run_until_quiet("b_read");

    // Tie at top address: A read 15 wins (old 0), then B writes 5.
    n = cyc;
    drive(0, 0, 4'd15, 4'h0);
    drive(1, 1, 4'd15, 4'h5);
    expect_cmd(0, 0, 4'd15, 4'h0, 4'h0, n + 3);
    expect_cmd(1, 1, 4'd15, 4'h5, 4'h0, n + 5);
    run_until_quiet("tie_a_first");

    n = cyc; drive(0, 0, 4'd15, 4'h0); expect_cmd(0, 0, 4'd15, 4'h0, 4'h5, n + 3);
    run_until_quiet("a_read15");

    // Tie with A last: B read 15 first (sees 5), then A writes C.
    n = cyc;
    drive(0, 1, 4'd15, 4'hC);
    drive(1, 0, 4'd15, 4'h0);
    expect_cmd(1, 0, 4'd15, 4'h0, 4'h5, n + 3);
    expect_cmd(0, 1, 4'd15, 4'hC, 4'h0, n + 5);
    run_until_quiet("tie_b_first");

    n = cyc; drive(0, 0, 4'd15, 4'h0); expect_cmd(0, 0, 4'd15, 4'h0, 4'hC, n + 3);
    run_until_quiet("a_read15_c");

    // Reset during ACCESS of a read: abort with no done.
    drive(0, 0, 4'd3, 4'h0);
    expect_cmd(0, 0, 4'd3, 4'h0, 4'h0, -1);
    void'(qa.pop_back());
    gcnt = 0;
    for (int i = 0; i < 20 && gcnt == 0; i++) begin
      @(negedge clk);
      #1;
      if (bus.a_gnt) gcnt = 1;
    end
    check("abort_gnt_seen", 32'(gcnt), 32'd1);
    bus.a_req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("abort_en", 32'({bus.ram_rd_n, bus.ram_wr_n}), 32'd3);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_pulses", 32'({bus.a_gnt, bus.b_gnt, bus.a_done, bus.b_done}), 32'd0);
    check("abort_addr", 32'(bus.ram_addr), 32'd0);
    check("abort_din", 32'(bus.ram_din), 32'd0);
    check("abort_rdata", 32'({bus.a_rdata, bus.b_rdata}), 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    check("abort_no_done", 32'(qa.size() + qb.size() + gq.size()), 32'd0);

    // After reset A wins the tie again.
    n = cyc;
    drive(0, 0, 4'd3, 4'h0);
    drive(1, 0, 4'd15, 4'h0);
    expect_cmd(0, 0, 4'd3, 4'h0, 4'hA, n + 3);
    expect_cmd(1, 0, 4'd15, 4'h0, 4'hC, n + 6);
    run_until_quiet("post_reset");

    // Random phase: only the per-cycle invariants apply.
    rnd = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      #1;
      if (bus.a_gnt) bus.a_req = 1'b0;
      else if (!bus.a_req && $urandom_range(0, 2) == 0) begin
        bus.a_req = 1'b1; bus.a_we = 1'($urandom);
        bus.a_addr = AW'($urandom); bus.a_wdata = DW'($urandom);
      end
      if (bus.b_gnt) bus.b_req = 1'b0;
      else if (!bus.b_req && $urandom_range(0, 2) == 0) begin
        bus.b_req = 1'b1; bus.b_we = 1'($urandom);
        bus.b_addr = AW'($urandom); bus.b_wdata = DW'($urandom);
      end
    end
    bus.a_req = 1'b0;
    bus.b_req = 1'b0;
    repeat (5) @(negedge clk);
    #1 rnd = 1'b0;
    check("final_idle", 32'(bus.busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
